paillier_homomorphic_adder: RTL and testbench

- Downstream consumer of the Paillier encryptor's 64-bit ciphertext.
- Computes c_sum = (c1 * c2) mod n^2. This is homomorphic addition: the result decrypts to m1 + m2 mod n.
- Multi-cycle, bit-serial datapath: shift-add squarer for n^2, then an interleaved MSB-first modular multiplier.
- Uses the same start/done handshake as the encryptor, so the two chain directly.

---
 rtl/paillier_pkg.sv | 21 ++
 rtl/paillier_modmul_step.sv | 33 +++
 rtl/paillier_homomorphic_adder.sv | 123 ++++++++++++
 tb/tb_paillier_homomorphic_adder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/paillier_pkg.sv
// Shared definitions for the Paillier homomorphic adder: bus width, FSM states
// and the expected start-to-done latency.
package paillier_pkg;

  localparam int W     = 64;
  localparam int IDX_W = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    SQUARE,
    CHECK,
    MULT,
    DONE
  } state_e;

  // Edges after the capture edge until done is visible.
  function automatic int expected_latency(input bit range_err);
    return range_err ? (W/2 + 1) : (W/2 + 1 + W);
  endfunction

endpackage

// File: rtl/paillier_modmul_step.sv
// One MSB-first interleaved modular-multiply step:
// acc_next = ((2*acc mod m) + (bit_in ? a : 0)) mod m.
module paillier_modmul_step
  import paillier_pkg::*;
(
  input  logic [W:0]   acc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  input  logic         bit_in,
  output logic [W:0]   acc_next
);

  logic [W+1:0] w_dbl;
  logic [W+1:0] w_red1;
  logic [W+1:0] w_sum;
  logic [W+1:0] w_red2;
  logic [W+1:0] w_m_ext;
  logic         w_unused_msb;

  assign w_m_ext = {2'b00, m};

  always_comb begin
    w_dbl  = {acc, 1'b0};
    w_red1 = (w_dbl >= w_m_ext) ? (w_dbl - w_m_ext) : w_dbl;
    w_sum  = bit_in ? (w_red1 + {2'b00, a}) : w_red1;
    w_red2 = (w_sum >= w_m_ext) ? (w_sum - w_m_ext) : w_sum;
  end

  // With acc < m and a < m the result is < m, so the top bit is always zero.
  assign w_unused_msb = w_red2[W+1];
  assign acc_next     = w_red2[W:0];

endmodule

// File: rtl/paillier_homomorphic_adder.sv
// Homomorphic Paillier addition: c_sum = (c1 * c2) mod n^2, bit-serial.
// Define PAILLIER_HOMADD_RANGE_CHECK_EN to enable input range checking (err).
module paillier_homomorphic_adder
  import paillier_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] c1,
  input  logic [W-1:0] c2,
  input  logic [W-1:0] n,
  output logic [W-1:0] c_sum,
  output logic         done,
  output logic         busy,
  output logic         err
);

  state_e           r_state;
  state_e           w_state_next;
  logic [W-1:0]     r_c1;
  logic [W-1:0]     r_c2;
  logic [W-1:0]     r_n;
  logic [W-1:0]     r_m;
  logic [W-1:0]     r_c_sum;
  logic [W:0]       r_acc;
  logic [W:0]       w_acc_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_err;
  logic             w_range_err;
  logic [W-1:0]     w_sq_addend;

`ifdef PAILLIER_HOMADD_RANGE_CHECK_EN
  assign w_range_err = (r_n == '0) || (r_n[W-1:W/2] != '0) ||
                       (r_c1 >= r_m) || (r_c2 >= r_m);
`else
  logic w_unused_n_hi;
  assign w_unused_n_hi = |r_n[W-1:W/2];
  assign w_range_err   = 1'b0;
`endif

  // Squarer consumes n MSB-first: m = 2*m + (n[idx] ? n_low : 0).
  assign w_sq_addend = r_n[r_idx] ? {{(W/2){1'b0}}, r_n[W/2-1:0]} : '0;

  paillier_modmul_step u_step (
    .acc      (r_acc),
    .a        (r_c1),
    .m        (r_m),
    .bit_in   (r_c2[r_idx]),
    .acc_next (w_acc_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SQUARE;
      SQUARE:  if (r_idx == '0) w_state_next = CHECK;
      CHECK:   w_state_next = w_range_err ? DONE : MULT;
      MULT:    if (r_idx == '0) w_state_next = DONE;
      DONE:    if (!start) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    done = (r_state == DONE);
    busy = (r_state == SQUARE) || (r_state == CHECK) || (r_state == MULT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c1    <= '0;
      r_c2    <= '0;
      r_n     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_c_sum <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_c1  <= c1;
            r_c2  <= c2;
            r_n   <= n;
            r_m   <= '0;
            r_acc <= '0;
            r_idx <= IDX_W'(W/2 - 1);
            r_err <= 1'b0;
          end
        end
        SQUARE: begin
          r_m   <= {r_m[W-2:0], 1'b0} + w_sq_addend;
          r_idx <= r_idx - 1'b1;
        end
        CHECK: begin
          if (w_range_err) begin
            r_err   <= 1'b1;
            r_c_sum <= '0;
          end else begin
            r_acc <= '0;
            r_idx <= IDX_W'(W - 1);
          end
        end
        MULT: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx - 1'b1;
          if (r_idx == '0) r_c_sum <= w_acc_next[W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign c_sum = r_c_sum;
  assign err   = r_err;

endmodule

// File: tb/tb_paillier_homomorphic_adder.sv
// Randomized self-checking bench for paillier_homomorphic_adder against a
// plain-arithmetic model of (c1*c2) mod n^2.
module tb_paillier_homomorphic_adder;
  import paillier_pkg::*;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] c1;
  logic [W-1:0] c2;
  logic [W-1:0] n;
  logic [W-1:0] c_sum;
  logic         done;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  paillier_homomorphic_adder dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .c1    (c1),
    .c2    (c2),
    .n     (n),
    .c_sum (c_sum),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] model_square(input logic [63:0] nn);
    logic [63:0] lo;
    lo = {32'b0, nn[31:0]};
    return lo * lo;
  endfunction

  function automatic logic [63:0] model_mulmod(input logic [63:0] a, input logic [63:0] b,
                                               input logic [63:0] m);
    logic [127:0] p;
    if (m == 0) return 64'd0;
    p = {64'b0, a} * {64'b0, b};
    return 64'(p % {64'b0, m});
  endfunction

  // Launch one operation, wait for done, compare, optionally hold start, then release.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] nn, input int hold);
    logic [63:0] m_exp;
    logic [63:0] sum_exp;
    bit          in_range;
    bit          err_exp;
    logic [63:0] held_sum;
    logic        held_err;
    int          lat;

    m_exp    = model_square(nn);
    in_range = (nn != 0) && (nn[63:32] == 0) && (a < m_exp) && (b < m_exp);
`ifdef PAILLIER_HOMADD_RANGE_CHECK_EN
    err_exp = !in_range;
`else
    err_exp = 1'b0;
`endif
    sum_exp = (in_range) ? model_mulmod(a, b, m_exp) : 64'd0;

    @(negedge clk);
    c1 = a; c2 = b; n = nn; start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_busy_after_capture"}, {63'b0, busy}, 64'd1);
    @(negedge clk);
    c1 = {$urandom, $urandom}; c2 = {$urandom, $urandom}; n = {$urandom, $urandom};

    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'(expected_latency(err_exp)));
    chk({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
    chk({tag, "_err"}, {63'b0, err}, {63'b0, err_exp});
    if (in_range || err_exp) chk({tag, "_c_sum"}, c_sum, sum_exp);
    $display("txn %s n=%0d c1=%0d c2=%0d c_sum=%0d err=%0b lat=%0d", tag, nn, a, b, c_sum, err, lat);

    held_sum = c_sum;
    held_err = err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      if (k == hold - 1) begin
        chk({tag, "_hold_done"}, {63'b0, done}, 64'd1);
        chk({tag, "_hold_busy"}, {63'b0, busy}, 64'd0);
      end
    end

    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, {63'b0, done}, 64'd0);
    if (hold > 0) begin
      chk({tag, "_sum_held"}, c_sum, held_sum);
      chk({tag, "_err_held"}, {63'b0, err}, {63'b0, held_err});
    end
  endtask

  initial begin
    logic [63:0] rn;
    logic [63:0] rm;
    logic [63:0] ra;
    logic [63:0] rb;

    rst = 1'b0; start = 1'b0; c1 = '0; c2 = '0; n = '0;
    #1;
    chk("reset_c_sum", c_sum, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_err", {63'b0, err}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_op("basic", 64'd2, 64'd3, 64'd3233, 0);
    run_op("large", 64'd5000000, 64'd3000000, 64'd3233, 0);
    run_op("bound_m1", 64'd10452288, 64'd1, 64'd3233, 0);
    run_op("bound_m", 64'd10452289, 64'd1, 64'd3233, 0);
    run_op("zero_c1", 64'd0, 64'd777, 64'd3233, 0);
    run_op("n_one", 64'd0, 64'd0, 64'd1, 0);
    run_op("n_zero", 64'd0, 64'd0, 64'd0, 0);
    run_op("n_2p32", 64'd5, 64'd7, 64'h1_0000_0000, 0);
    run_op("max_n", 64'hFFFF_FFFE_0000_0000, 64'hFFFF_FFFE_0000_0000, 64'hFFFF_FFFF, 0);

    // Asynchronous reset in the middle of MULT.
    @(negedge clk);
    c1 = 64'd5000000; c2 = 64'd3000000; n = 64'd3233; start = 1'b1;
    @(posedge clk);
    repeat (50) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_done", {63'b0, done}, 64'd0);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_c_sum", c_sum, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op("after_rst", 64'd2, 64'd3, 64'd3233, 0);

    run_op("hold", 64'd12345, 64'd67890, 64'd3233, 20);
    run_op("second", 64'd2, 64'd3, 64'd3233, 0);

    for (int t = 0; t < 16; t++) begin
      rn = {32'b0, $urandom};
      if (t < 4) rn = 64'($urandom_range(2, 200));
      if (rn == 0) rn = 64'd1;
      rm = model_square(rn);
      ra = {$urandom, $urandom} % rm;
      rb = {$urandom, $urandom} % rm;
      if (t == 5) ra = rm - 1;
      if (t == 6) rb = rm - 1;
      run_op($sformatf("rand%0d", t), ra, rb, rn, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
